axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  AXI4 initiator that turns one local command (addr, beat count, rd/wr) into a single INCR burst.
//  Write data comes from a valid/ready stream; read data leaves on a valid/ready stream.
//  Drives AXI4 RAM responders and peripheral slaves for DMA-style block copies and self-test.
//  One transaction outstanding at a time; AW/W and AR/R phases are strictly sequential.
// PARAMETERS
//  DATA_WIDTH  32             AXI data width, bits; power-of-two multiple of 8
//  ADDR_WIDTH  16             AXI address width, bits
//  STRB_WIDTH  DATA_WIDTH/8   wstrb width
//  ID_WIDTH    8              AXI ID width
//  AXI_ID      0              constant ID driven on awid/arid and expected on bid/rid
// PORTS
//  clk         in   1          clock, all logic rising-edge
//  rst_n       in   1          reset, asynchronous assert, active-low
//  cmd_valid   in   1          command request
//  cmd_ready   out  1          command accepted when valid&ready
//  cmd_write   in   1          1 = write burst, 0 = read burst
//  cmd_addr    in   ADDR_WIDTH byte address; low log2(STRB_WIDTH) bits ignored (forced 0)
//  cmd_len     in   8          beats minus one (0..255)
//  wr_tdata    in   DATA_WIDTH write payload stream
//  wr_tvalid   in   1          / wr_tready out 1: write stream handshake
//  rd_tdata    out  DATA_WIDTH read payload stream; rd_tlast out 1 on final beat
//  rd_tvalid   out  1          / rd_tready in 1: read stream handshake
//  done        out  1          one-cycle pulse at command completion
//  err         out  1          valid with done: 1 = command failed
//  m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid} out / m_axi_awready in
//  m_axi_w{data,strb,last,valid} out / m_axi_wready in
//  m_axi_b{id,resp,valid} in / m_axi_bready out
//  m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid} out / m_axi_arready in
//  m_axi_r{id,data,resp,last,valid} in / m_axi_rready out
// BEHAVIOUR
//  Reset (rst_n=0): state IDLE; cmd_ready, awvalid, wvalid, bready, arvalid, rready, rd_tvalid,
//   rd_tlast, done, err all 0; address/len regs 0. Takes effect immediately, mid-burst included;
//   the aborted command produces no done. cmd_ready rises on first clk after release.
//  FSM: IDLE -> AW -> W -> B -> IDLE (write); IDLE -> AR -> R -> IDLE (read).
//  IDLE: cmd_ready=1. On accept at edge N: latch cmd; awvalid/arvalid high from cycle N+1.
//  4 KB check: if aligned_addr[11:0] + (cmd_len+1)*STRB_WIDTH > 4096, no AXI traffic;
//   done=1, err=1 at N+1, back to IDLE.
//  Constant fields: size=$clog2(STRB_WIDTH), burst=INCR(2'b01), lock=0, cache=4'b0011, prot=0,
//   wstrb all ones, id=AXI_ID. axvalid held with stable fields until axready.
//  W: m_axi_wvalid=wr_tvalid, wr_tready=m_axi_wready (combinational, state W only); 8-bit beat
//   counter from 0; wlast=1 when count==len; after last beat handshake -> B.
//  B: bready=1; on bvalid: err_next = (bresp!=0) | (bid!=AXI_ID); done/err registered, one cycle later.
//  R: rd_tvalid=m_axi_rvalid, m_axi_rready=rd_tready, rd_tdata=rdata, rd_tlast=rlast (state R only).
//   Sticky error: any rresp!=0, rid!=AXI_ID, rlast on a non-final beat, or rlast missing on final.
//   Final beat (count==len) handshake -> done next cycle with sticky err; IDLE.
//  cmd_ready=0 outside IDLE; new command accepted earliest the cycle after done.
//  Simultaneous: awready coincident with awvalid rising completes in one cycle; stalls
//   (wvalid/rready low) hold counter.
// STRUCTURE
//  Package axi_master_pkg: FSM state enum, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR,
//   AXI_CACHE_DEFAULT constants.
//  Single module; beat counter and 4 KB check inline, no sub-module.
// TESTING
//  Write len=3 @0x0100 data 1..4, slave ready always -> awlen=3, wlast on beat 4, done err=0.
//  Read len=0 @0x0204 -> araddr=0x0204, one rd beat rd_tlast=1, done err=0.
//  Write len=7, bresp=SLVERR -> done=1 err=1 one cycle after B handshake.
//  Read len=3, slave rlast on beat 2 -> all 4 beats forwarded, done with err=1.
//  cmd_addr=0x0FF8 len=3 (crosses 4 KB) -> no awvalid, done+err at N+1.
//  rst_n low mid-W burst -> all valids 0 same cycle, no done; next command runs clean.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and AXI4 encodings for the single-burst AXI master.
// The FSM encoding lives here so benches and wrappers can decode state if needed.
package axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;

  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 initiator: one local command becomes one INCR burst, write data from a stream,
// read data to a stream, with a one-cycle done/err pulse at completion.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 16,
  parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wr_tdata,
  input  logic                  wr_tvalid,
  output logic                  wr_tready,

  output logic [DATA_WIDTH-1:0] rd_tdata,
  output logic                  rd_tlast,
  output logic                  rd_tvalid,
  input  logic                  rd_tready,

  output logic                  done,
  output logic                  err,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  // Holds cmd_ready low while reset is asserted and releases it on the first edge after.
  logic                    init_q;

  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic [31:0]             span_bytes;
  logic                    crosses_4k;
  logic                    accept;
  logic                    last_beat;
  logic                    w_hs;
  logic                    r_hs;
  logic                    r_beat_err;

  assign aligned_addr = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  // End of burst measured from the start of its 4 KB page; reaching exactly 4096 is legal.
  assign span_bytes   = 32'(aligned_addr[11:0])
                      + ((32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH));
  assign crosses_4k   = (span_bytes > 32'd4096);

  assign accept     = cmd_valid && (state_q == ST_IDLE) && init_q;
  assign last_beat  = (cnt_q == len_q);
  assign w_hs       = (state_q == ST_W) && wr_tvalid && m_axi_wready;
  assign r_hs       = (state_q == ST_R) && m_axi_rvalid && rd_tready;
  assign r_beat_err = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rid != AXI_ID)
                   || (m_axi_rlast != last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (crosses_4k)     state_d = ST_DONE;
          else if (cmd_write) state_d = ST_AW;
          else                state_d = ST_AR;
        end
      end
      ST_AW:   if (m_axi_awready)     state_d = ST_W;
      ST_W:    if (w_hs && last_beat) state_d = ST_B;
      ST_B:    if (m_axi_bvalid)      state_d = ST_DONE;
      ST_AR:   if (m_axi_arready)     state_d = ST_R;
      ST_R:    if (r_hs && last_beat) state_d = ST_DONE;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == ST_IDLE) && init_q;
    m_axi_awvalid = (state_q == ST_AW);
    m_axi_arvalid = (state_q == ST_AR);
    m_axi_wvalid  = (state_q == ST_W) && wr_tvalid;
    wr_tready     = (state_q == ST_W) && m_axi_wready;
    m_axi_wlast   = (state_q == ST_W) && last_beat;
    m_axi_bready  = (state_q == ST_B);
    m_axi_rready  = (state_q == ST_R) && rd_tready;
    rd_tvalid     = (state_q == ST_R) && m_axi_rvalid;
    rd_tlast      = (state_q == ST_R) && m_axi_rlast;
    rd_tdata      = (state_q == ST_R) ? m_axi_rdata : '0;
    done          = (state_q == ST_DONE);
    err           = (state_q == ST_DONE) && err_q;
  end

  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (accept) begin
      addr_d = aligned_addr;
      len_d  = cmd_len;
      cnt_d  = 8'd0;
      err_d  = crosses_4k;
    end
    if (w_hs) begin
      cnt_d = cnt_q + 8'd1;
    end
    if ((state_q == ST_B) && m_axi_bvalid) begin
      err_d = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != AXI_ID);
    end
    // Read errors are sticky so one bad beat taints the whole command.
    if (r_hs) begin
      cnt_d = cnt_q + 8'd1;
      err_d = err_q || r_beat_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      init_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      init_q <= 1'b1;
    end
  end

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;

  assign m_axi_wdata   = wr_tdata;
  assign m_axi_wstrb   = '1;

  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: an AXI slave/stream model drives the DUT and a
// per-cycle protocol model derives every expected output from the burst rules.
module tb_axi_burst_master;
  import axi_master_pkg::*;

  localparam logic [7:0] ID = 8'h3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_tdata;
  logic        wr_tvalid, wr_tready;
  logic [31:0] rd_tdata;
  logic        rd_tlast, rd_tvalid, rd_tready;
  logic        done, err;
  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] wdata, rdata;

  axi_burst_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .AXI_ID(ID)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tlast(rd_tlast), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready),
    .done(done), .err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] rdata_of(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  // Stimulus-owned configuration of the slave and stream partners.
  logic        cfg_stall_w, cfg_stall_r, cfg_aw_slow, cfg_bid_bad;
  logic [1:0]  cfg_bresp, cfg_rresp;
  int          cfg_last_beat, cfg_bad_beat;
  logic [31:0] wdat [256];

  // Model state, owned by the compare process.
  int          cyc = 0;
  logic        busy, aw_pend, ar_pend, w_ph, b_ph, r_ph, done_pend, m_err;
  logic [15:0] cur_addr;
  logic [7:0]  cur_len;
  int          w_beat, r_beat;
  int          n_done = 0, n_aw = 0, n_ar = 0, n_w = 0, n_r = 0;
  logic        last_err;
  int          last_done_cyc, hs_end_cyc, accept_cyc, wlast_beat;
  logic [15:0] cap_awaddr, cap_araddr;
  logic [7:0]  cap_awlen;

  // AXI slave + write-stream source + read-stream sink.
  logic        s_wactive, s_bpend, s_ractive;
  int          s_widx, s_rbeat;
  logic [15:0] s_raddr;
  logic [7:0]  s_rlen;
  initial begin : slave
    logic h_aw, h_w, h_wl, h_b, h_ar, h_r;
    logic [15:0] h_araddr;
    logic [7:0]  h_arlen;
    s_wactive = 0; s_bpend = 0; s_ractive = 0; s_widx = 0; s_rbeat = 0;
    s_raddr = 0; s_rlen = 0;
    awready = 0; arready = 0; wready = 0; wr_tvalid = 0; wr_tdata = 0;
    bvalid = 0; bresp = 0; bid = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
    rd_tready = 0;
    forever begin
      @(negedge clk);
      h_aw = awvalid & awready;  h_w = wvalid & wready;  h_wl = wlast;
      h_b = bvalid & bready;     h_ar = arvalid & arready; h_r = rvalid & rready;
      h_araddr = araddr;         h_arlen = arlen;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_wactive = 0; s_bpend = 0; s_ractive = 0; s_widx = 0; s_rbeat = 0;
      end else begin
        if (h_aw) begin s_wactive = 1; s_widx = 0; end
        if (h_w) begin
          s_widx++;
          if (h_wl) begin s_wactive = 0; s_bpend = 1; end
        end
        if (h_b) s_bpend = 0;
        if (h_ar) begin s_ractive = 1; s_raddr = h_araddr; s_rlen = h_arlen; s_rbeat = 0; end
        if (h_r) begin
          if (s_rbeat == int'(s_rlen)) s_ractive = 0;
          s_rbeat++;
        end
      end
      awready   = !cfg_aw_slow || (cyc % 3 == 0);
      arready   = !cfg_aw_slow || (cyc % 3 == 0);
      wready    = !cfg_stall_w || (cyc % 2 == 0);
      wr_tvalid = s_wactive && (!cfg_stall_w || (cyc % 3 != 1));
      wr_tdata  = wdat[s_widx & 255];
      bvalid    = s_bpend;
      bresp     = cfg_bresp;
      bid       = cfg_bid_bad ? (ID ^ 8'h01) : ID;
      rvalid    = s_ractive && (!cfg_stall_r || (cyc % 3 != 0));
      rdata     = rdata_of(16'(s_raddr + 16'(4 * s_rbeat)));
      rlast     = (s_rbeat == cfg_last_beat);
      rresp     = (s_rbeat == cfg_bad_beat) ? cfg_rresp : AXI_RESP_OKAY;
      rid       = ID;
      rd_tready = !cfg_stall_r || (cyc % 2 == 1);
    end
  end

  // Compare process: expectations follow from the burst/handshake rules, checked every cycle.
  initial begin : compare
    logic [10:0] got_v, exp_v;
    int off;
    busy = 0; aw_pend = 0; ar_pend = 0; w_ph = 0; b_ph = 0; r_ph = 0; done_pend = 0;
    m_err = 0; cur_addr = 0; cur_len = 0; w_beat = 0; r_beat = 0; last_err = 0;
    last_done_cyc = 0; hs_end_cyc = 0; accept_cyc = 0; wlast_beat = -1;
    cap_awaddr = 0; cap_araddr = 0; cap_awlen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                              rd_tvalid, rd_tlast, done, err}, 0);
        busy = 0; aw_pend = 0; ar_pend = 0; w_ph = 0; b_ph = 0; r_ph = 0; done_pend = 0;
        continue;
      end
      got_v = {cmd_ready, awvalid, arvalid, wvalid, wr_tready, bready, rready,
               rd_tvalid, rd_tlast, done, err};
      exp_v = {!busy, aw_pend, ar_pend, w_ph & wr_tvalid, w_ph & wready, b_ph,
               r_ph & rd_tready, r_ph & rvalid, r_ph & rlast, done_pend, done_pend & m_err};
      chk("ctl_signals", 64'(got_v), 64'(exp_v));
      if (awvalid)
        chk("aw_fields", {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot},
            {ID, cur_addr, cur_len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
      if (arvalid)
        chk("ar_fields", {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot},
            {ID, cur_addr, cur_len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
      if (wvalid) chk("w_strb", 64'(wstrb), 64'hF);

      if (done_pend) begin
        done_pend = 0; busy = 0; n_done++; last_done_cyc = cyc; last_err = m_err;
        $display("txn %0d done cycle=%0d addr=%h len=%0d err=%0d", n_done, cyc,
                 cur_addr, cur_len, err);
      end
      if (cmd_valid && cmd_ready) begin
        busy = 1; accept_cyc = cyc;
        cur_addr = cmd_addr & 16'hFFFC; cur_len = cmd_len;
        off = int'(cur_addr & 16'h0FFF);
        if (off + (int'(cmd_len) + 1) * 4 > 4096) begin
          m_err = 1; done_pend = 1;
        end else begin
          m_err = 0;
          if (cmd_write) aw_pend = 1; else ar_pend = 1;
        end
      end
      if (awvalid && awready) begin
        aw_pend = 0; w_ph = 1; w_beat = 0; n_aw++; cap_awaddr = awaddr; cap_awlen = awlen;
      end
      if (wvalid && wready) begin
        chk("w_data", 64'(wdata), 64'(wdat[w_beat & 255]));
        chk("w_last", 64'(wlast), 64'(w_beat == int'(cur_len)));
        if (wlast) wlast_beat = w_beat;
        n_w++;
        if (w_beat == int'(cur_len)) begin w_ph = 0; b_ph = 1; end
        w_beat++;
      end
      if (bvalid && bready) begin
        b_ph = 0; done_pend = 1; hs_end_cyc = cyc;
        m_err = (bresp != AXI_RESP_OKAY) || (bid != ID);
      end
      if (arvalid && arready) begin
        ar_pend = 0; r_ph = 1; r_beat = 0; n_ar++; cap_araddr = araddr;
      end
      if (rd_tvalid && rd_tready) begin
        chk("rd_data", 64'(rd_tdata), 64'(rdata_of(16'(cur_addr + 16'(4 * r_beat)))));
        if (rresp != AXI_RESP_OKAY || rid != ID || (rlast != (r_beat == int'(cur_len))))
          m_err = 1;
        n_r++;
        if (r_beat == int'(cur_len)) begin r_ph = 0; done_pend = 1; hs_end_cyc = cyc; end
        r_beat++;
      end
    end
  end

  task automatic set_defaults();
    cfg_stall_w = 0; cfg_stall_r = 0; cfg_aw_slow = 0; cfg_bid_bad = 0;
    cfg_bresp = AXI_RESP_OKAY; cfg_rresp = AXI_RESP_OKAY;
    cfg_last_beat = -1; cfg_bad_beat = -1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                           input logic [31:0] wbase);
    bit ok;
    for (int i = 0; i < 256; i++) wdat[i] = wbase + 32'(i);
    if (cfg_last_beat < 0) cfg_last_beat = int'(len);
    @(posedge clk); #1;
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [31:0] wbase, input logic exp_err, input string nm);
    int d0;
    bit ok;
    d0 = n_done;
    issue_cmd(wr, addr, len, wbase);
    ok = (n_done > d0);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (n_done > d0) ok = 1;
    end
    if (!ok) chk({nm, "_done_timeout"}, 0, 1);
    else chk({nm, "_err"}, 64'(last_err), 64'(exp_err));
    @(negedge clk);
    set_defaults();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n0, a0;
    bit ok;
    set_defaults();
    for (int i = 0; i < 256; i++) wdat[i] = 0;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;

    // Write len=3 @0x0100, data 1..4, slave always ready.
    n0 = n_w;
    run_cmd(1, 16'h0100, 8'd3, 32'd1, 0, "wr4");
    chk("wr4_awaddr", 64'(cap_awaddr), 64'h0100);
    chk("wr4_awlen", 64'(cap_awlen), 64'd3);
    chk("wr4_beats", 64'(n_w - n0), 64'd4);
    chk("wr4_wlast_beat", 64'(wlast_beat), 64'd3);

    // Read single beat @0x0204.
    n0 = n_r;
    run_cmd(0, 16'h0204, 8'd0, 32'd0, 0, "rd1");
    chk("rd1_araddr", 64'(cap_araddr), 64'h0204);
    chk("rd1_beats", 64'(n_r - n0), 64'd1);

    // Write len=7 with SLVERR response; done exactly one cycle after B handshake.
    cfg_bresp = AXI_RESP_SLVERR;
    run_cmd(1, 16'h0400, 8'd7, 32'hA000_0000, 1, "wr8_slverr");
    chk("wr8_done_latency", 64'(last_done_cyc - hs_end_cyc), 64'd1);

    // Read len=3 with rlast on beat 2: all four beats forwarded, sticky error.
    n0 = n_r;
    cfg_last_beat = 1;
    run_cmd(0, 16'h0300, 8'd3, 32'd0, 1, "rd4_early_last");
    chk("rd4_beats", 64'(n_r - n0), 64'd4);

    // Burst crossing 4 KB: no AXI traffic, done+err the cycle after accept.
    n0 = n_aw;
    run_cmd(1, 16'h0FF8, 8'd3, 32'd0, 1, "cross4k");
    chk("cross4k_no_aw", 64'(n_aw - n0), 64'd0);
    chk("cross4k_latency", 64'(last_done_cyc - accept_cyc), 64'd1);

    // Burst ending exactly on the 4 KB boundary is legal.
    n0 = n_ar;
    run_cmd(0, 16'h0FF0, 8'd3, 32'd0, 0, "edge4k");
    chk("edge4k_ar", 64'(n_ar - n0), 64'd1);

    // Maximum length read, ends exactly at 0x1000.
    n0 = n_r;
    run_cmd(0, 16'h0C00, 8'd255, 32'd0, 0, "rd256");
    chk("rd256_beats", 64'(n_r - n0), 64'd256);

    // Misaligned address, stalled streams, slow AW.
    cfg_stall_w = 1; cfg_aw_slow = 1;
    run_cmd(1, 16'h0103, 8'd5, 32'h5500_0000, 0, "wr_stall");
    chk("wr_stall_awaddr", 64'(cap_awaddr), 64'h0100);

    // Stalled read with DECERR on one beat.
    cfg_stall_r = 1; cfg_aw_slow = 1; cfg_bad_beat = 2; cfg_rresp = AXI_RESP_DECERR;
    run_cmd(0, 16'h0800, 8'd4, 32'd0, 1, "rd_decerr");

    // Single-beat write with wrong BID.
    cfg_bid_bad = 1;
    run_cmd(1, 16'h0010, 8'd0, 32'h0000_BEEF, 1, "wr_badid");

    // Reset in the middle of a write burst.
    cfg_stall_w = 1;
    issue_cmd(1, 16'h0500, 8'd7, 32'h7700_0000);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (w_ph && w_beat >= 2) ok = 1;
    end
    if (!ok) chk("midburst_wait_timeout", 0, 1);
    a0 = n_done;
    #1 rst_n = 0;
    #1 chk("rst_async_outputs", {awvalid, wvalid, bready, arvalid, rready, rd_tvalid,
                                 rd_tlast, done, err, cmd_ready}, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 64'(n_done - a0), 64'd0);
    set_defaults();
    n0 = n_w;
    run_cmd(1, 16'h0600, 8'd1, 32'h0000_0100, 0, "wr_after_rst");
    chk("wr_after_rst_beats", 64'(n_w - n0), 64'd2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
